// File: rtl/axi4l_sram_slave.sv
// AXI4-Lite slave terminating AW/W/B/AR/R onto a word-organised single-port SRAM.
// Writes commit once both address and data are held and no B response is pending.
// Reads fetch one cycle after AR capture unless a write commit claims the port that cycle.
module axi4l_sram_slave #(
   parameter int unsigned              ADDR_WIDTH = 32,
   parameter int unsigned              DATA_WIDTH = 32,
   parameter int unsigned              DEPTH      = 1024,
   parameter logic [ADDR_WIDTH-1:0]    BASE_ADDR  = '0
) (
   input  logic                      aclk,
   input  logic                      aresetn,
   // write address
   input  logic                      awvalid,
   output logic                      awready,
   input  logic [ADDR_WIDTH-1:0]     awaddr,
   input  logic [2:0]                awprot,
   // write data
   input  logic                      wvalid,
   output logic                      wready,
   input  logic [DATA_WIDTH-1:0]     wdata,
   input  logic [DATA_WIDTH/8-1:0]   wstrb,
   // write response
   output logic                      bvalid,
   input  logic                      bready,
   output logic [1:0]                bresp,
   // read address
   input  logic                      arvalid,
   output logic                      arready,
   input  logic [ADDR_WIDTH-1:0]     araddr,
   input  logic [2:0]                arprot,
   // read data
   output logic                      rvalid,
   input  logic                      rready,
   output logic [DATA_WIDTH-1:0]     rdata,
   output logic [1:0]                rresp
);

   localparam int unsigned           STRB        = DATA_WIDTH / 8;
   localparam int unsigned           LSB         = $clog2(STRB);
   localparam int unsigned           IDX_W       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [ADDR_WIDTH-1:0] DEPTH_A     = ADDR_WIDTH'(DEPTH);
   localparam logic [1:0]            RESP_OKAY   = 2'b00;
   localparam logic [1:0]            RESP_SLVERR = 2'b10;

   // protection attributes carry no meaning for a plain memory
   logic unused_prot;
   assign unused_prot = ^{awprot, arprot};

   // ---------------------------------------------------------------------------
   // State
   // ---------------------------------------------------------------------------
   logic                  rdy_en_q, rdy_en_d;     // keeps readies low until first edge after reset
   logic                  aw_held_q, aw_held_d;
   logic                  aw_ok_q, aw_ok_d;
   logic [IDX_W-1:0]      aw_idx_q, aw_idx_d;
   logic                  w_held_q, w_held_d;
   logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
   logic [STRB-1:0]       wstrb_q, wstrb_d;
   logic                  bvalid_q, bvalid_d;
   logic [1:0]            bresp_q, bresp_d;
   logic                  ar_held_q, ar_held_d;
   logic                  ar_ok_q, ar_ok_d;
   logic [IDX_W-1:0]      ar_idx_q, ar_idx_d;
   logic                  rvalid_q, rvalid_d;
   logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
   logic [1:0]            rresp_q, rresp_d;

   logic [DATA_WIDTH-1:0] mem [DEPTH];

   // ---------------------------------------------------------------------------
   // Address decode of the incoming channels; result is registered at capture
   // ---------------------------------------------------------------------------
   logic [ADDR_WIDTH-1:0] aw_word, ar_word;
   logic                  aw_in_range, ar_in_range;

   // word index relative to BASE_ADDR; byte-offset bits are dropped
   always_comb begin
      aw_word     = (awaddr - BASE_ADDR) >> LSB;
      ar_word     = (araddr - BASE_ADDR) >> LSB;
      aw_in_range = (awaddr >= BASE_ADDR) && (aw_word < DEPTH_A);
      ar_in_range = (araddr >= BASE_ADDR) && (ar_word < DEPTH_A);
   end

   // ---------------------------------------------------------------------------
   // Handshakes and port arbitration
   // ---------------------------------------------------------------------------
   logic aw_hs, w_hs, b_hs, ar_hs, r_hs;
   logic commit, fetch, mem_we;
   logic [DATA_WIDTH-1:0] mem_rdata;

   assign awready = rdy_en_q & ~aw_held_q;
   assign wready  = rdy_en_q & ~w_held_q;
   assign arready = rdy_en_q & ~ar_held_q & ~rvalid_q;
   assign bvalid  = bvalid_q;
   assign bresp   = bresp_q;
   assign rvalid  = rvalid_q;
   assign rdata   = rdata_q;
   assign rresp   = rresp_q;

   assign aw_hs  = awvalid & awready;
   assign w_hs   = wvalid & wready;
   assign b_hs   = bvalid_q & bready;
   assign ar_hs  = arvalid & arready;
   assign r_hs   = rvalid_q & rready;
   // a write commit owns the single SRAM port; a pending fetch waits one cycle
   assign commit = aw_held_q & w_held_q & ~bvalid_q;
   assign fetch  = ar_held_q & ~commit;
   assign mem_we = commit & aw_ok_q;

   // SRAM read data for the held read address
   always_comb begin
      mem_rdata = mem[ar_idx_q];
   end

   // write channel capture, commit and B response
   always_comb begin
      rdy_en_d  = 1'b1;
      aw_held_d = aw_held_q;
      aw_ok_d   = aw_ok_q;
      aw_idx_d  = aw_idx_q;
      w_held_d  = w_held_q;
      wdata_d   = wdata_q;
      wstrb_d   = wstrb_q;
      bvalid_d  = bvalid_q;
      bresp_d   = bresp_q;
      if (commit) begin
         aw_held_d = 1'b0;
         w_held_d  = 1'b0;
         bvalid_d  = 1'b1;
         bresp_d   = aw_ok_q ? RESP_OKAY : RESP_SLVERR;
      end
      if (aw_hs) begin
         aw_held_d = 1'b1;
         aw_ok_d   = aw_in_range;
         aw_idx_d  = aw_word[IDX_W-1:0];
      end
      if (w_hs) begin
         w_held_d = 1'b1;
         wdata_d  = wdata;
         wstrb_d  = wstrb;
      end
      if (b_hs) begin
         bvalid_d = 1'b0;
      end
   end

   // read channel capture, fetch and R response
   always_comb begin
      ar_held_d = ar_held_q;
      ar_ok_d   = ar_ok_q;
      ar_idx_d  = ar_idx_q;
      rvalid_d  = rvalid_q;
      rdata_d   = rdata_q;
      rresp_d   = rresp_q;
      if (ar_hs) begin
         ar_held_d = 1'b1;
         ar_ok_d   = ar_in_range;
         ar_idx_d  = ar_word[IDX_W-1:0];
      end
      if (fetch) begin
         ar_held_d = 1'b0;
         rvalid_d  = 1'b1;
         rdata_d   = ar_ok_q ? mem_rdata : '0;
         rresp_d   = ar_ok_q ? RESP_OKAY : RESP_SLVERR;
      end
      if (r_hs) begin
         rvalid_d = 1'b0;
      end
   end

   // control and response registers; everything visible clears on reset
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         rdy_en_q  <= 1'b0;
         aw_held_q <= 1'b0;
         aw_ok_q   <= 1'b0;
         aw_idx_q  <= '0;
         w_held_q  <= 1'b0;
         wdata_q   <= '0;
         wstrb_q   <= '0;
         bvalid_q  <= 1'b0;
         bresp_q   <= 2'b00;
         ar_held_q <= 1'b0;
         ar_ok_q   <= 1'b0;
         ar_idx_q  <= '0;
         rvalid_q  <= 1'b0;
         rdata_q   <= '0;
         rresp_q   <= 2'b00;
      end else begin
         rdy_en_q  <= rdy_en_d;
         aw_held_q <= aw_held_d;
         aw_ok_q   <= aw_ok_d;
         aw_idx_q  <= aw_idx_d;
         w_held_q  <= w_held_d;
         wdata_q   <= wdata_d;
         wstrb_q   <= wstrb_d;
         bvalid_q  <= bvalid_d;
         bresp_q   <= bresp_d;
         ar_held_q <= ar_held_d;
         ar_ok_q   <= ar_ok_d;
         ar_idx_q  <= ar_idx_d;
         rvalid_q  <= rvalid_d;
         rdata_q   <= rdata_d;
         rresp_q   <= rresp_d;
      end
   end

   // SRAM write port: only strobed byte lanes change; contents survive reset
   always_ff @(posedge aclk) begin
      if (mem_we) begin
         for (int b = 0; b < STRB; b++) begin
            if (wstrb_q[b]) mem[aw_idx_q][8*b +: 8] <= wdata_q[8*b +: 8];
         end
      end
   end

endmodule

// File: tb/tb_axi4l_sram_slave.sv
// Scoreboard bench for axi4l_sram_slave: drivers push expected B/R responses from a
// word-array model; a negedge monitor pops and compares on every B and R handshake.
module tb_axi4l_sram_slave;

   logic        aclk = 1'b0;
   logic        aresetn = 1'b0;
   logic        awvalid = 1'b0, awready;
   logic [31:0] awaddr = '0;
   logic [2:0]  awprot = '0;
   logic        wvalid = 1'b0, wready;
   logic [31:0] wdata = '0;
   logic [3:0]  wstrb = '0;
   logic        bvalid, bready = 1'b0;
   logic [1:0]  bresp;
   logic        arvalid = 1'b0, arready;
   logic [31:0] araddr = '0;
   logic [2:0]  arprot = '0;
   logic        rvalid, rready = 1'b0;
   logic [31:0] rdata;
   logic [1:0]  rresp;

   axi4l_sram_slave #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .DEPTH(1024), .BASE_ADDR(32'h0)) dut (
      .aclk(aclk), .aresetn(aresetn),
      .awvalid(awvalid), .awready(awready), .awaddr(awaddr), .awprot(awprot),
      .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb),
      .bvalid(bvalid), .bready(bready), .bresp(bresp),
      .arvalid(arvalid), .arready(arready), .araddr(araddr), .arprot(arprot),
      .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp)
   );

   always #5 aclk = ~aclk;

   typedef struct { logic [31:0] data; logic [1:0] resp; } r_exp_t;

   int          vectors = 0, miscompares = 0;
   int          b_issued = 0, b_done = 0, r_issued = 0, r_done = 0;
   int          rdy_mode = 0;  // 0: always ready, 1: random, 2: bready held low
   logic [1:0]  exp_b [$];
   r_exp_t      exp_r [$];
   logic [31:0] model [0:1023];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // response-side ready generation, driven just after each rising edge
   always @(posedge aclk) begin
      #2;
      case (rdy_mode)
         0:       begin bready = 1'b1; rready = 1'b1; end
         1:       begin bready = ($urandom_range(0, 3) != 0); rready = ($urandom_range(0, 3) != 0); end
         default: begin bready = 1'b0; rready = 1'b1; end
      endcase
   end

   // monitor: every completed B/R handshake is checked against the queued expectation
   always @(negedge aclk) begin
      if (aresetn) begin
         if (bvalid && bready) begin
            if (exp_b.size() == 0) chk("b_unexpected", 64'(bresp), 64'hFF);
            else chk("bresp", 64'(bresp), 64'(exp_b.pop_front()));
            b_done++;
         end
         if (rvalid && rready) begin
            if (exp_r.size() == 0) chk("r_unexpected", 64'(rdata), 64'hFF);
            else begin
               r_exp_t e;
               e = exp_r.pop_front();
               chk("rdata", 64'(rdata), 64'(e.data));
               chk("rresp", 64'(rresp), 64'(e.resp));
            end
            r_done++;
         end
      end
   end

   // ---------------- reference model ----------------
   task automatic exp_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
      if (a < 32'h1000) begin
         for (int b = 0; b < 4; b++) if (s[b]) model[a[11:2]][8*b +: 8] = d[8*b +: 8];
         exp_b.push_back(2'b00);
      end else begin
         exp_b.push_back(2'b10);
      end
      b_issued++;
   endtask

   task automatic exp_read(input logic [31:0] a);
      r_exp_t e;
      if (a < 32'h1000) begin e.data = model[a[11:2]]; e.resp = 2'b00; end
      else begin e.data = '0; e.resp = 2'b10; end
      exp_r.push_back(e);
      r_issued++;
   endtask

   // ---------------- drivers (called at posedge + 1) ----------------
   task automatic wait_edge();
      @(posedge aclk); #1;
   endtask

   task automatic send_aw(input logic [31:0] a);
      bit hs = 0;
      int n = 0;
      awvalid = 1'b1; awaddr = a;
      while (!hs && n < 100) begin @(negedge aclk); hs = awready; @(posedge aclk); #1; n++; end
      awvalid = 1'b0;
      if (!hs) chk("aw_timeout", 64'(hs), 64'd1);
   endtask

   task automatic send_w(input logic [31:0] d, input logic [3:0] s);
      bit hs = 0;
      int n = 0;
      wvalid = 1'b1; wdata = d; wstrb = s;
      while (!hs && n < 100) begin @(negedge aclk); hs = wready; @(posedge aclk); #1; n++; end
      wvalid = 1'b0;
      if (!hs) chk("w_timeout", 64'(hs), 64'd1);
   endtask

   task automatic send_ar(input logic [31:0] a);
      bit hs = 0;
      int n = 0;
      arvalid = 1'b1; araddr = a;
      while (!hs && n < 100) begin @(negedge aclk); hs = arready; @(posedge aclk); #1; n++; end
      arvalid = 1'b0;
      if (!hs) chk("ar_timeout", 64'(hs), 64'd1);
   endtask

   task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                           input int aw_dly, input int w_dly);
      exp_write(a, d, s);
      fork
         begin repeat (aw_dly) wait_edge(); send_aw(a); end
         begin repeat (w_dly) wait_edge(); send_w(d, s); end
      join
   endtask

   task automatic do_read(input logic [31:0] a);
      exp_read(a);
      send_ar(a);
   endtask

   task automatic wait_idle();
      int n = 0;
      while ((b_done < b_issued || r_done < r_issued) && n < 300) begin wait_edge(); n++; end
      if (b_done < b_issued) chk("b_timeout", 64'(b_done), 64'(b_issued));
      if (r_done < r_issued) chk("r_timeout", 64'(r_done), 64'(r_issued));
   endtask

   // ---------------- stimulus ----------------
   initial begin
      logic [31:0] a, d;
      int          sel, skew;

      // reset state
      repeat (3) wait_edge();
      chk("rst_outs", 64'({awready, wready, arready, bvalid, rvalid, bresp, rresp}), 64'd0);
      chk("rst_rdata", 64'(rdata), 64'd0);
      aresetn = 1'b1;
      chk("rdy_before_edge", 64'({awready, wready, arready}), 64'd0);
      wait_edge();
      chk("rdy_after_edge", 64'({awready, wready, arready}), 64'b111);

      // preload the working window of words 0..31
      for (int i = 0; i < 32; i++) begin
         do_write(32'(i * 4), $urandom, 4'hF, 0, 0);
         wait_idle();
      end

      // aligned write then read, with latency checks
      do_write(32'h10, 32'hDEADBEEF, 4'hF, 0, 0);
      chk("b_lat_n", 64'(bvalid), 64'd0);
      wait_edge();
      chk("b_lat_n1", 64'(bvalid), 64'd1);
      wait_idle();
      do_read(32'h10);
      chk("r_lat_n", 64'(rvalid), 64'd0);
      wait_edge();
      chk("r_lat_n1", 64'(rvalid), 64'd1);
      wait_idle();

      // byte strobes
      do_write(32'h20, 32'h11223344, 4'hF, 0, 0); wait_idle();
      do_write(32'h20, 32'hAABBCCDD, 4'b0101, 0, 0); wait_idle();
      do_read(32'h20); wait_idle();

      // W leads AW by three cycles
      exp_write(32'h30, 32'h0BADF00D, 4'hF);
      send_w(32'h0BADF00D, 4'hF);
      repeat (3) begin chk("wready_held", 64'(wready), 64'd0); wait_edge(); end
      send_aw(32'h30);
      chk("skew_w_b_n", 64'(bvalid), 64'd0);
      wait_edge();
      chk("skew_w_b_n1", 64'(bvalid), 64'd1);
      wait_idle();
      // AW leads W by three cycles
      exp_write(32'h34, 32'hCAFE0123, 4'hF);
      send_aw(32'h34);
      repeat (3) begin chk("awready_held", 64'(awready), 64'd0); wait_edge(); end
      send_w(32'hCAFE0123, 4'hF);
      chk("skew_aw_b_n", 64'(bvalid), 64'd0);
      wait_edge();
      chk("skew_aw_b_n1", 64'(bvalid), 64'd1);
      wait_idle();
      do_read(32'h30); do_read(32'h34); wait_idle();

      // B backpressure with a second write queued behind it
      rdy_mode = 2;
      do_write(32'h44, 32'h44444444, 4'hF, 0, 0);
      wait_edge();
      repeat (5) begin
         chk("bp_bvalid", 64'(bvalid), 64'd1);
         chk("bp_bresp", 64'(bresp), 64'd0);
         wait_edge();
      end
      do_write(32'h48, 32'h48484848, 4'hF, 0, 0);
      chk("bp_awready", 64'(awready), 64'd0);
      chk("bp_wready", 64'(wready), 64'd0);
      wait_edge();
      chk("bp_full", 64'({awready, wready, bvalid}), 64'b001);
      rdy_mode = 0;
      wait_edge();
      chk("bp_gap", 64'(bvalid), 64'd0);
      wait_edge();
      chk("bp_second_b", 64'(bvalid), 64'd1);
      wait_idle();
      do_read(32'h44); do_read(32'h48); wait_idle();

      // out of range: write dropped, read returns zero with SLVERR
      do_write(32'h1000, 32'h12345678, 4'hF, 0, 0); wait_idle();
      do_read(32'h1000); wait_idle();
      do_read(32'h0); wait_idle();

      // commit and fetch collide on 0x40: fetch slips one cycle, sees new data
      exp_write(32'h40, 32'h40404040, 4'hF);
      exp_read(32'h40);
      fork
         send_aw(32'h40);
         send_w(32'h40404040, 4'hF);
         send_ar(32'h40);
      join
      chk("cf_n", 64'({bvalid, rvalid}), 64'b00);
      wait_edge();
      chk("cf_n1", 64'({bvalid, rvalid}), 64'b10);
      wait_edge();
      chk("cf_n2_rvalid", 64'(rvalid), 64'd1);
      wait_idle();

      // randomized traffic with random ready backpressure
      rdy_mode = 1;
      for (int i = 0; i < 150; i++) begin
         sel = int'($urandom_range(0, 9));
         if (sel == 0)      a = 32'h1000 + $urandom_range(0, 255);
         else if (sel == 1) a = 32'hFFFF_FFF0;
         else               a = $urandom_range(0, 31) * 4 + $urandom_range(0, 3);
         if ($urandom_range(0, 1) == 1) begin
            d    = $urandom;
            skew = int'($urandom_range(0, 6)) - 3;
            if (skew < 0) do_write(a, d, 4'($urandom_range(0, 15)), -skew, 0);
            else          do_write(a, d, 4'($urandom_range(0, 15)), 0, skew);
         end else begin
            do_read(a);
         end
         wait_idle();
      end
      rdy_mode = 0;
      wait_edge(); wait_edge();

      // reset with only AW captured: the orphan address must never commit
      send_aw(32'h50);
      aresetn = 1'b0;
      #1;
      chk("mid_rst_outs", 64'({awready, wready, arready, bvalid, rvalid}), 64'd0);
      wait_edge(); wait_edge();
      chk("mid_rst_hold", 64'({awready, wready, arready, bvalid, rvalid}), 64'd0);
      aresetn = 1'b1;
      chk("mid_rel_rdy0", 64'({awready, wready, arready}), 64'd0);
      wait_edge();
      chk("mid_rel_rdy1", 64'({awready, wready, arready}), 64'b111);
      send_w(32'h5555AAAA, 4'hF);
      repeat (3) begin chk("orphan_no_b", 64'(bvalid), 64'd0); wait_edge(); end
      exp_write(32'h54, 32'h5555AAAA, 4'hF);
      send_aw(32'h54);
      wait_idle();
      do_read(32'h50); do_read(32'h54); wait_idle();

      chk("exp_b_empty", 64'(exp_b.size()), 64'd0);
      chk("exp_r_empty", 64'(exp_r.size()), 64'd0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
